// File: rtl/car_game_pkg.sv
// Shared constants and FSM encoding for the car sprite draw path.
package car_game_pkg;
  localparam int SPR_LOG2 = 3;
  localparam int XW       = 8;
  localparam int YW       = 7;
  localparam int CW       = 3;
  localparam int SCR_W    = 160;
  localparam int SCR_H    = 120;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DRAIN = 2'd3
  } draw_state_t;
endpackage

// File: rtl/sprite_scan_cnt.sv
// Row/col raster counter over one sprite; wraps to {0,0} after the last pixel.
module sprite_scan_cnt #(
  parameter int SPR_LOG2 = car_game_pkg::SPR_LOG2
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                en,
  output logic [SPR_LOG2-1:0] row,
  output logic [SPR_LOG2-1:0] col,
  output logic                last
);
  assign last = (&row) & (&col);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      col <= col + 1'b1;
      if (&col) row <= row + 1'b1;
    end
  end
endmodule

// File: rtl/car_draw_ctrl.sv
// Car sprite draw sequencer: per accepted move, optional background erase then car draw.
// Optional erase pass is enabled by defining CAR_ERASE_EN.
module car_draw_ctrl
  import car_game_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  req,
  input  logic [XW-1:0]         new_x,
  input  logic [YW-1:0]         new_y,
  output logic                  ack,
  output logic                  busy,
  output logic                  done,
  output logic [2*SPR_LOG2-1:0] car_addr,
  input  logic [CW-1:0]         car_q,
  output logic [XW+YW-1:0]      bg_addr,
  input  logic [CW-1:0]         bg_q,
  output logic [XW-1:0]         vga_x,
  output logic [YW-1:0]         vga_y,
  output logic [CW-1:0]         vga_colour,
  output logic                  vga_plot
);
  localparam logic [XW:0] SCR_W_C = (XW+1)'(SCR_W);
  localparam logic [YW:0] SCR_H_C = (YW+1)'(SCR_H);

`ifdef CAR_ERASE_EN
  localparam draw_state_t FIRST_PH = ST_ERASE;
`else
  localparam draw_state_t FIRST_PH = ST_DRAW;
`endif

  draw_state_t state, state_nxt;
  logic [XW-1:0] tgt_x, cur_x, base_x;
  logic [YW-1:0] tgt_y, cur_y, base_y;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic [SPR_LOG2-1:0] row, col;
  logic scan_en, scan_last, accept, pix_vis, act_q, erase_ph;

  sprite_scan_cnt #(.SPR_LOG2(SPR_LOG2)) u_scan (
    .Clock (Clock),
    .Resetn(Resetn),
    .en    (scan_en),
    .row   (row),
    .col   (col),
    .last  (scan_last)
  );

  always_comb begin
    state_nxt = state;
    scan_en   = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE:  if (req) begin accept = 1'b1; state_nxt = FIRST_PH; end
      ST_ERASE: begin scan_en = 1'b1; if (scan_last) state_nxt = ST_DRAW; end
      ST_DRAW:  begin scan_en = 1'b1; if (scan_last) state_nxt = ST_DRAIN; end
      ST_DRAIN: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign erase_ph = (state == ST_ERASE);

`ifdef CAR_ERASE_EN
  logic [XW-1:0] old_x;
  logic [YW-1:0] old_y;
  logic          src_bg_q;
  assign base_x     = erase_ph ? old_x : tgt_x;
  assign base_y     = erase_ph ? old_y : tgt_y;
  assign bg_addr    = erase_ph ? {sum_y[YW-1:0], sum_x[XW-1:0]} : '0;
  assign vga_colour = act_q ? (src_bg_q ? bg_q : car_q) : '0;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      old_x    <= '0;
      old_y    <= '0;
      src_bg_q <= 1'b0;
    end else begin
      src_bg_q <= erase_ph;
      if (accept) begin
        old_x <= cur_x;
        old_y <= cur_y;
      end
    end
  end
`else
  // Without erase the background ROM and the current position have no consumer.
  logic unused_sink;
  assign unused_sink = ^{bg_q, cur_x, cur_y, erase_ph};
  assign base_x      = tgt_x;
  assign base_y      = tgt_y;
  assign bg_addr     = '0;
  assign vga_colour  = act_q ? car_q : '0;
`endif

  // One extra bit keeps the carry so off-screen pixels never wrap back on.
  assign sum_x    = {1'b0, base_x} + {{(XW+1-SPR_LOG2){1'b0}}, col};
  assign sum_y    = {1'b0, base_y} + {{(YW+1-SPR_LOG2){1'b0}}, row};
  assign pix_vis  = (sum_x < SCR_W_C) && (sum_y < SCR_H_C);
  assign car_addr = {row, col};

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state    <= ST_IDLE;
      ack      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tgt_x    <= '0;
      tgt_y    <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      act_q    <= 1'b0;
      vga_plot <= 1'b0;
      vga_x    <= '0;
      vga_y    <= '0;
    end else begin
      state    <= state_nxt;
      ack      <= accept;
      done     <= (state == ST_DRAIN);
      act_q    <= scan_en;
      vga_plot <= scan_en & pix_vis;
      if (accept) begin
        busy  <= 1'b1;
        tgt_x <= new_x;
        tgt_y <= new_y;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (state == ST_DRAIN) begin
        cur_x <= tgt_x;
        cur_y <= tgt_y;
      end
      // Coordinates travel alongside the ROM address so they line up with ROM data.
      if (scan_en) begin
        vga_x <= sum_x[XW-1:0];
        vga_y <= sum_y[YW-1:0];
      end
    end
  end
endmodule
